// File: rtl/minmax_pkg.sv
// Shared types and default widths for the min/max frame reduction block.
// Imported by minmax_acc and minmax_frame_ctrl.
package minmax_pkg;

   localparam int DATA_DEF  = 8;
   localparam int LEN_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_t;

endpackage

// File: rtl/minmax_acc.sv
// Running min/max accumulator, with optional argmin/argmax registers.
// Index tracking is built only when MINMAX_IDX_EN is defined.
module minmax_acc
   import minmax_pkg::*;
#(
   parameter int DATA  = DATA_DEF
`ifdef MINMAX_IDX_EN
  ,parameter int LEN_W = LEN_W_DEF
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [DATA-1:0]  din,
`ifdef MINMAX_IDX_EN
   input  logic [LEN_W-1:0] idx,
   output logic [LEN_W-1:0] min_idx,
   output logic [LEN_W-1:0] max_idx,
`endif
   output logic [DATA-1:0]  min_val,
   output logic [DATA-1:0]  max_val
);

   // NOTE: non-blocking assignments so every compare sees the pre-edge min/max.
   always_ff @(posedge clk) begin
      if (rst) begin
         min_val <= '0;
         max_val <= '0;
      end else if (load) begin
         min_val <= din;
         max_val <= din;
      end else if (en) begin
         // Strict compares: an equal sample never displaces the earlier winner.
         if (din < min_val) min_val <= din;
         if (din > max_val) max_val <= din;
      end
   end

`ifdef MINMAX_IDX_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         min_idx <= '0;
         max_idx <= '0;
      end else if (load) begin
         min_idx <= idx;
         max_idx <= idx;
      end else if (en) begin
         if (din < min_val) min_idx <= idx;
         if (din > max_val) max_idx <= idx;
      end
   end
`endif

endmodule

// File: rtl/minmax_frame_ctrl.sv
// Frame sequencer for a streaming min/max reduction (IDLE -> SCAN -> DONE).
// Define MINMAX_IDX_EN to add the min_idx/max_idx ports and index registers.
module minmax_frame_ctrl
   import minmax_pkg::*;
#(
   parameter int DATA  = DATA_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DATA-1:0]  in_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [DATA-1:0]  Min,
   output logic [DATA-1:0]  Max,
`ifdef MINMAX_IDX_EN
   output logic [LEN_W-1:0] min_idx,
   output logic [LEN_W-1:0] max_idx,
`endif
   output logic             busy
);

   state_t           state, state_nxt;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] count;
   logic             beat;
   logic             last_beat;
   logic             open_frame;

   assign in_ready   = (state == SCAN);
   assign res_valid  = (state == DONE);
   assign busy       = (state != IDLE);
   assign beat       = in_valid & in_ready;
   assign last_beat  = beat && (count == len_q - LEN_W'(1));
   assign open_frame = (state == IDLE) && start && (len != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         len_q <= '0;
         count <= '0;
      end else begin
         state <= state_nxt;
         if (open_frame) begin
            len_q <= len;
            count <= '0;
         end else if (beat) begin
            count <= count + LEN_W'(1);
         end
      end
   end

   // NOTE: default first so no path through the case leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (open_frame) state_nxt = SCAN;
         SCAN: if (last_beat)  state_nxt = DONE;
         DONE: if (res_ready)  state_nxt = IDLE;
         default:              state_nxt = IDLE;
      endcase
   end

   minmax_acc #(
      .DATA  (DATA)
`ifdef MINMAX_IDX_EN
     ,.LEN_W (LEN_W)
`endif
   ) u_acc (
      .clk     (clk),
      .rst     (rst),
      .load    (beat && (count == '0)),
      .en      (beat && (count != '0)),
      .din     (in_data),
`ifdef MINMAX_IDX_EN
      .idx     (count),
      .min_idx (min_idx),
      .max_idx (max_idx),
`endif
      .min_val (Min),
      .max_val (Max)
   );

endmodule

// File: tb/tb_minmax_frame_ctrl.sv
// Directed self-checking bench for minmax_frame_ctrl; inputs change and outputs
// are sampled on the falling edge. Index checks compile only with MINMAX_IDX_EN.
module tb_minmax_frame_ctrl;

   localparam int DATA  = 8;
   localparam int LEN_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [LEN_W-1:0] len;
   logic             in_valid;
   logic             in_ready;
   logic [DATA-1:0]  in_data;
   logic             res_valid;
   logic             res_ready;
   logic [DATA-1:0]  Min;
   logic [DATA-1:0]  Max;
`ifdef MINMAX_IDX_EN
   logic [LEN_W-1:0] min_idx;
   logic [LEN_W-1:0] max_idx;
`endif
   logic             busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   minmax_frame_ctrl #(.DATA(DATA), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .Min       (Min),
      .Max       (Max),
`ifdef MINMAX_IDX_EN
      .min_idx   (min_idx),
      .max_idx   (max_idx),
`endif
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic open_frame(input logic [LEN_W-1:0] l);
      start = 1'b1;
      len   = l;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [DATA-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic consume();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("consume_res_valid", res_valid, 1'b0);
      check("consume_busy", busy, 1'b0);
   endtask

   task automatic check_idx(input string tag, input logic [LEN_W-1:0] emin,
                            input logic [LEN_W-1:0] emax);
`ifdef MINMAX_IDX_EN
      check({tag, "_min_idx"}, min_idx, emin);
      check({tag, "_max_idx"}, max_idx, emax);
`else
      if (emin > emax && emax > emin) $display("unreachable %s", tag);
`endif
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      len       = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      res_ready = 1'b0;
      tick();
      tick();
      check("rst_busy", busy, 1'b0);
      check("rst_res_valid", res_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_min", Min, 8'h00);
      check("rst_max", Max, 8'h00);
      check_idx("rst", 8'd0, 8'd0);
      rst = 1'b0;
      tick();

      // Test 1: back-to-back 5,2,9,2; result one cycle after the last beat.
      open_frame(8'd4);
      check("t1_in_ready", in_ready, 1'b1);
      check("t1_busy", busy, 1'b1);
      send(8'd5);
      send(8'd2);
      send(8'd9);
      check("t1_no_early_valid", res_valid, 1'b0);
      send(8'd2);
      check("t1_res_valid", res_valid, 1'b1);
      check("t1_in_ready_done", in_ready, 1'b0);
      check("t1_min", Min, 8'd2);
      check("t1_max", Max, 8'd9);
      check_idx("t1", 8'd1, 8'd2);
      consume();
      check("t1_min_retained", Min, 8'd2);
      check("t1_max_retained", Max, 8'd9);

      // Test 2: single sample, consumer stalls for 5 cycles.
      open_frame(8'd1);
      send(8'h80);
      for (int i = 0; i < 5; i++) begin
         check("t2_hold_valid", res_valid, 1'b1);
         check("t2_hold_min", Min, 8'h80);
         check("t2_hold_max", Max, 8'h80);
         tick();
      end
      check_idx("t2", 8'd0, 8'd0);
      consume();

      // Test 3: gapped valid 1,0,0,1,0,1 with equal samples.
      open_frame(8'd3);
      send(8'd7);
      tick();
      tick();
      check("t3_gap_in_ready", in_ready, 1'b1);
      send(8'd7);
      tick();
      check("t3_gap_no_valid", res_valid, 1'b0);
      send(8'd7);
      check("t3_res_valid", res_valid, 1'b1);
      check("t3_min", Min, 8'd7);
      check("t3_max", Max, 8'd7);
      check_idx("t3", 8'd0, 8'd0);
      consume();

      // Test 4: zero-length start ignored; start during SCAN/DONE ignored.
      open_frame(8'd0);
      check("t4_len0_busy", busy, 1'b0);
      tick();
      check("t4_len0_valid", res_valid, 1'b0);
      open_frame(8'd2);
      send(8'd10);
      start = 1'b1;
      len   = 8'd2;
      send(8'd20);
      start = 1'b0;
      check("t4_done_after_2", res_valid, 1'b1);
      check("t4_min", Min, 8'd10);
      check("t4_max", Max, 8'd20);
      check_idx("t4", 8'd0, 8'd1);
      start = 1'b1;
      len   = 8'd5;
      consume();
      start = 1'b0;
      tick();
      check("t4_start_in_done_ignored", busy, 1'b0);

      // Test 5: reset mid-frame, then a fresh len=2 frame.
      open_frame(8'd4);
      send(8'h30);
      send(8'h40);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_rst_busy", busy, 1'b0);
      check("t5_rst_in_ready", in_ready, 1'b0);
      check("t5_rst_min", Min, 8'h00);
      check("t5_rst_max", Max, 8'h00);
      open_frame(8'd2);
      send(8'hFF);
      send(8'h00);
      check("t5_res_valid", res_valid, 1'b1);
      check("t5_min", Min, 8'h00);
      check("t5_max", Max, 8'hFF);
      check_idx("t5", 8'd1, 8'd0);
      consume();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
